// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the sequence-scanning arbiter and its
// serial "1011" detector.
package seq_scan_pkg;

  // Controller states for the arbiter front end.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Detector states: Sn means the last n bits match the first n bits of "1011".
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_t;

  // Length of the detected pattern "1011".
  localparam int PAT_LEN = 4;

endpackage

// File: rtl/seq1011_det.sv
// Moore detector for the overlapping serial pattern "1011".
// A clear returns it to S0 and wins over enable; with enable low it holds.
module seq1011_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  det_state_t state;
  det_state_t state_next;

  // State register: reset and clear go to S0, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= S0;
    end else if (clear) begin
      state <= S0;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next-state function of the overlapping "1011" recogniser.
  always_comb begin
    // NOTE: a default assigned first keeps this block free of inferred latches.
    state_next = S0;
    unique case (state)
      S0:      state_next = bit_in ? S1 : S0;
      S1:      state_next = bit_in ? S1 : S2;
      S2:      state_next = bit_in ? S3 : S0;
      S3:      state_next = bit_in ? S4 : S2;
      S4:      state_next = bit_in ? S1 : S2;
      default: state_next = S0;
    endcase
  end

  assign match = (state == S4);

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin front end sharing one serial "1011" detector between two
// word-wide requesters. Each accepted frame is shifted MSB-first, matches
// within that frame are counted, and the count plus requester ID are
// returned on a valid/ready result channel.
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_id,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count;
  logic              id_q;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              det_clear;
  logic              det_en;
  logic              det_match;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and controller outputs; detector is cleared on the accept edge.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    det_clear  = 1'b0;
    det_en     = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          det_clear  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        det_en = 1'b1;
        if (bit_idx == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: capture on accept, shift during SHIFT, count matches
  // lagging one bit behind the shifter (DRAIN catches the final bit).
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_idx    <= '0;
      count      <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            shreg      <= grant1 ? req1_data : req0_data;
            id_q       <= grant1;
            last_grant <= grant1;
            count      <= '0;
            bit_idx    <= '0;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          bit_idx <= bit_idx + IDX_W'(1);
          if ((bit_idx != '0) && det_match) count <= count + CNT_W'(1);
        end
        DRAIN: begin
          if (det_match) count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  seq1011_det u_det (
    .clk    (clk),
    .reset  (reset),
    .clear  (det_clear),
    .en     (det_en),
    .bit_in (shreg[DATA_W-1]),
    .match  (det_match)
  );

  assign res_count = count;
  assign res_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed self-checking bench for seq_scan_arbiter (DATA_W=16, CNT_W=5).
module tb_seq_scan_arbiter;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;
  localparam int LAT    = DATA_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_id;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  seq_scan_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one frame, check handshake, latency, count and id, then consume the result.
  task automatic run_frame(input logic id, input logic [DATA_W-1:0] d, input int exp_cnt,
                           input string tag);
    int   n;
    logic rdy;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    #1;
    n   = 0;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 50) begin
      step();
      n++;
      rdy = id ? req1_ready : req0_ready;
    end
    check({tag, " ready"}, 32'(rdy), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " count"}, 32'(res_count), 32'(exp_cnt));
    check({tag, " id"}, 32'(res_id), 32'(id));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int   n;
    logic exp_id;

    reset      = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    res_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("rst busy", 32'(busy), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_count", 32'(res_count), 32'd0);
    check("rst res_id", 32'(res_id), 32'd0);
    check("rst ready idle", 32'({req1_ready, req0_ready}), 32'd0);
    // Tie right after reset goes to req0; withdraw before the edge.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst first tie", 32'({req1_ready, req0_ready}), 32'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Basic frames and cross-frame isolation.
    run_frame(1'b0, 16'hB000, 1, "b000");
    run_frame(1'b1, 16'hB6DB, 5, "b6db");
    run_frame(1'b0, 16'h0000, 0, "zero");
    run_frame(1'b1, 16'hFFFF, 0, "ones");
    run_frame(1'b0, 16'h0001, 0, "iso a");
    run_frame(1'b0, 16'h6000, 0, "iso b");

    // Both requesters valid continuously: grants alternate starting with req0.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'hB000;
    req1_valid = 1'b1;
    req1_data  = 16'hB6DB;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_id = g[0];
      n = 0;
      while (!(req0_ready || req1_ready) && n < 50) begin
        step();
        n++;
      end
      check($sformatf("arb%0d grant", g), 32'({req1_ready, req0_ready}),
            exp_id ? 32'b10 : 32'b01);
      step();
      check($sformatf("arb%0d busy ready", g), 32'({req1_ready, req0_ready}), 32'd0);
      n = 1;
      while (!res_valid && n < 40) begin
        step();
        n++;
      end
      check($sformatf("arb%0d id", g), 32'(res_id), 32'(exp_id));
      check($sformatf("arb%0d count", g), 32'(res_count), exp_id ? 32'd5 : 32'd1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    step();

    // Reset in the middle of SHIFT, then a fresh frame.
    req0_valid = 1'b1;
    req0_data  = 16'hB6DB;
    #1;
    check("midrst accept", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst res_valid", 32'(res_valid), 32'd0);
    check("midrst count", 32'(res_count), 32'd0);
    run_frame(1'b0, 16'hB000, 1, "post rst");

    // Consumer stalls for 5 cycles while req0 waits.
    req1_valid = 1'b1;
    req1_data  = 16'hB6DB;
    #1;
    check("stall accept", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 16'h1234;
    n = 1;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    check("stall latency", 32'(n), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d valid", i), 32'(res_valid), 32'd1);
      check($sformatf("stall%0d count", i), 32'(res_count), 32'd5);
      check($sformatf("stall%0d id", i), 32'(res_id), 32'd1);
      check($sformatf("stall%0d no ready", i), 32'({req1_ready, req0_ready}), 32'd0);
      step();
    end
    res_ready = 1'b1;
    check("stall done ready", 32'(req0_ready), 32'd0);
    step();
    res_ready = 1'b0;
    check("stall released", 32'(res_valid), 32'd0);
    check("stall next grant", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    check("f1234 latency", 32'(n), 32'(LAT));
    check("f1234 count", 32'(res_count), 32'd0);
    check("f1234 id", 32'(res_id), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
